// File: rtl/spi_mem_master.sv
// spi_mem_master: SPI mode-0 initiator for 25xx EEPROMs (16-bit address) behind a single-byte memory port.
// Optional feature macro: SPI_MEM_MASTER_WIP_POLL_EN adds RDSR polling until WIP clears after each write.
module spi_mem_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        mem_begin_rd,
    input  logic        mem_begin_wr,
    input  logic [15:0] mem_addr,
    input  logic [7:0]  mem_data_wr,
    output logic [7:0]  mem_data_rd,
    output logic        mem_finish,
    output logic        busy,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs
);

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);
    localparam logic [7:0]  CMD_READ  = 8'h03;
    localparam logic [7:0]  CMD_WRITE = 8'h02;
    localparam logic [7:0]  CMD_WREN  = 8'h06;
`ifdef SPI_MEM_MASTER_WIP_POLL_EN
    localparam logic [7:0]  CMD_RDSR  = 8'h05;

    typedef enum logic [2:0] {
        IDLE = 3'd0, WREN = 3'd1, GAP = 3'd2, XFER = 3'd3,
        POLL = 3'd4, POLL_GAP = 3'd5, DONE = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, WREN = 3'd1, GAP = 3'd2, XFER = 3'd3, DONE = 3'd6
    } state_t;
`endif

    state_t      state_r;
    logic        spi_cs_r, spi_clk_r, spi_mosi_r, mem_finish_r, busy_r;
    logic [7:0]  mem_data_rd_r;
    logic        op_wr_r;
    logic [15:0] addr_r;
    logic [7:0]  data_r;
    logic [31:0] frame_r;
    logic [1:0]  last_byte_r;
    logic [7:0]  tx_sh_r, rx_sh_r;
    logic [7:0]  div_r;
    logic [2:0]  bit_r;
    logic [1:0]  byte_r;
    logic        tail_r;
    logic [15:0] gap_r;

    logic        start_s;
    logic [31:0] start_frame_s;
    logic [1:0]  start_last_s;
    logic [7:0]  next_byte_s;
    logic        frame_end_s;

    function automatic logic [7:0] frame_byte(input logic [31:0] frame, input logic [1:0] idx);
        case (idx)
            2'd0:    return frame[31:24];
            2'd1:    return frame[23:16];
            2'd2:    return frame[15:8];
            default: return frame[7:0];
        endcase
    endfunction

    assign next_byte_s = frame_byte(frame_r, byte_r + 2'd1);
    // The trailing half-period after the last falling edge is the only place a frame can end
    assign frame_end_s = !spi_cs_r && tail_r && (div_r == DIV_LAST);

    // Decide when a new CS frame begins and which bytes it carries
    always_comb begin
        start_s       = 1'b0;
        start_frame_s = 32'h0000_0000;
        start_last_s  = 2'd0;
        case (state_r)
            IDLE: begin
                if (mem_begin_rd) begin
                    start_s       = 1'b1;
                    start_frame_s = {CMD_READ, mem_addr, 8'h00};
                    start_last_s  = 2'd3;
                end else if (mem_begin_wr) begin
                    start_s       = 1'b1;
                    start_frame_s = {CMD_WREN, 24'h00_0000};
                    start_last_s  = 2'd0;
                end else begin
                    start_s = 1'b0;
                end
            end
            GAP: begin
                if (gap_r == GAP_LAST) begin
                    start_s       = 1'b1;
                    start_frame_s = {CMD_WRITE, addr_r, data_r};
                    start_last_s  = 2'd3;
                end else begin
                    start_s = 1'b0;
                end
            end
`ifdef SPI_MEM_MASTER_WIP_POLL_EN
            POLL_GAP: begin
                if (gap_r == GAP_LAST) begin
                    start_s       = 1'b1;
                    start_frame_s = {CMD_RDSR, 24'h00_0000};
                    start_last_s  = 2'd1;
                end else begin
                    start_s = 1'b0;
                end
            end
`endif
            default: start_s = 1'b0;
        endcase
    end

    // Operation sequencer plus SPI bit engine; every output comes straight from a register
    always_ff @(posedge mclk) begin
        if (!reset) begin
            state_r       <= IDLE;
            spi_cs_r      <= 1'b1;
            spi_clk_r     <= 1'b0;
            spi_mosi_r    <= 1'b0;
            mem_finish_r  <= 1'b0;
            busy_r        <= 1'b0;
            mem_data_rd_r <= 8'h00;
            op_wr_r       <= 1'b0;
            addr_r        <= 16'h0000;
            data_r        <= 8'h00;
            frame_r       <= 32'h0000_0000;
            last_byte_r   <= 2'd0;
            tx_sh_r       <= 8'h00;
            rx_sh_r       <= 8'h00;
            div_r         <= 8'd0;
            bit_r         <= 3'd0;
            byte_r        <= 2'd0;
            tail_r        <= 1'b0;
            gap_r         <= 16'd0;
        end else begin
            mem_finish_r <= 1'b0;

            if (!spi_cs_r) begin
                if (div_r != DIV_LAST) begin
                    div_r <= div_r + 8'd1;
                end else begin
                    div_r <= 8'd0;
                    if (tail_r) begin
                        spi_cs_r <= 1'b1;
                        tail_r   <= 1'b0;
                        gap_r    <= 16'd0;
                    end else if (!spi_clk_r) begin
                        spi_clk_r <= 1'b1;
                        rx_sh_r   <= {rx_sh_r[6:0], spi_miso};
                    end else begin
                        spi_clk_r <= 1'b0;
                        if (bit_r == 3'd7) begin
                            bit_r <= 3'd0;
                            if (byte_r == last_byte_r) begin
                                tail_r     <= 1'b1;
                                spi_mosi_r <= 1'b0;
                            end else begin
                                byte_r     <= byte_r + 2'd1;
                                tx_sh_r    <= next_byte_s;
                                spi_mosi_r <= next_byte_s[7];
                            end
                        end else begin
                            bit_r      <= bit_r + 3'd1;
                            tx_sh_r    <= {tx_sh_r[6:0], 1'b0};
                            spi_mosi_r <= tx_sh_r[6];
                        end
                    end
                end
            end

            case (state_r)
                IDLE: begin
                    if (mem_begin_rd) begin
                        op_wr_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= XFER;
                    end else if (mem_begin_wr) begin
                        op_wr_r <= 1'b1;
                        addr_r  <= mem_addr;
                        data_r  <= mem_data_wr;
                        busy_r  <= 1'b1;
                        state_r <= WREN;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                WREN: begin
                    if (frame_end_s) state_r <= GAP;
                end
                GAP: begin
                    gap_r <= gap_r + 16'd1;
                    if (gap_r == GAP_LAST) state_r <= XFER;
                end
                XFER: begin
                    if (frame_end_s) begin
                        if (op_wr_r) begin
`ifdef SPI_MEM_MASTER_WIP_POLL_EN
                            state_r <= POLL_GAP;
`else
                            state_r      <= DONE;
                            mem_finish_r <= 1'b1;
`endif
                        end else begin
                            state_r       <= DONE;
                            mem_finish_r  <= 1'b1;
                            mem_data_rd_r <= rx_sh_r;
                        end
                    end
                end
`ifdef SPI_MEM_MASTER_WIP_POLL_EN
                POLL: begin
                    if (frame_end_s) begin
                        if (rx_sh_r[0]) begin
                            state_r <= POLL_GAP;
                        end else begin
                            state_r      <= DONE;
                            mem_finish_r <= 1'b1;
                        end
                    end
                end
                POLL_GAP: begin
                    gap_r <= gap_r + 16'd1;
                    if (gap_r == GAP_LAST) state_r <= POLL;
                end
`endif
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase

            if (start_s) begin
                spi_cs_r    <= 1'b0;
                spi_clk_r   <= 1'b0;
                div_r       <= 8'd0;
                bit_r       <= 3'd0;
                byte_r      <= 2'd0;
                tail_r      <= 1'b0;
                frame_r     <= start_frame_s;
                last_byte_r <= start_last_s;
                tx_sh_r     <= start_frame_s[31:24];
                spi_mosi_r  <= start_frame_s[31];
            end
        end
    end

    assign spi_cs      = spi_cs_r;
    assign spi_clk     = spi_clk_r;
    assign spi_mosi    = spi_mosi_r;
    assign mem_finish  = mem_finish_r;
    assign busy        = busy_r;
    assign mem_data_rd = mem_data_rd_r;

endmodule

// File: tb/tb_spi_mem_master.sv
// Directed bench for spi_mem_master: an EEPROM-like MISO model plus a frame recorder on the SPI pins.
module tb_spi_mem_master;

    logic        mclk = 1'b0;
    logic        reset;
    logic        mem_begin_rd, mem_begin_wr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_wr, mem_data_rd;
    logic        mem_finish, busy, spi_clk, spi_mosi, spi_miso, spi_cs;

    spi_mem_master #(.CLK_DIV(4), .CS_GAP(8)) dut (
        .mclk(mclk), .reset(reset), .mem_begin_rd(mem_begin_rd), .mem_begin_wr(mem_begin_wr),
        .mem_addr(mem_addr), .mem_data_wr(mem_data_wr), .mem_data_rd(mem_data_rd),
        .mem_finish(mem_finish), .busy(busy), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_cs(spi_cs)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        int          nbits;
        logic [31:0] word;
        int          fall;
        int          rise;
        int          gap;
    } frame_t;

    frame_t      frames_q[$];
    frame_t      fr;
    int          cyc = 0;
    int          chk_cnt = 0, pass_cnt = 0;
    int          cur_nbits = 0, cur_fall = 0, cur_gap = 0, cs_hi_run = 0;
    logic [31:0] cur_word = 32'h0;
    int          fin_cnt = 0, fin_cyc = 0, clk_cs_hi = 0, rdsr_cnt = 0;
    int          hi_run = 0, hi_min = 1000, hi_max = 0;
    logic        prev_clk = 1'b0, prev_cs = 1'b1;
    logic [7:0]  rd_val = 8'h00;
    int          wip_frames = 0;
    logic [7:0]  status_val;

    always @(posedge mclk) cyc <= cyc + 1;

    assign status_val = (rdsr_cnt < wip_frames) ? 8'h01 : 8'h00;

    // Slave model: status byte on bits 8..15, read data on bits 24..31 of each frame
    always_comb begin
        if (cur_nbits >= 24 && cur_nbits < 32) spi_miso = rd_val[31 - cur_nbits];
        else if (cur_nbits >= 8 && cur_nbits < 16) spi_miso = status_val[15 - cur_nbits];
        else spi_miso = 1'b0;
    end

    // Pin monitor, sampled mid-cycle
    always @(negedge mclk) begin
        if (spi_clk && !prev_clk) begin
            if (spi_cs) clk_cs_hi++;
            else begin
                cur_word = {cur_word[30:0], spi_mosi};
                cur_nbits++;
            end
        end
        if (!reset) begin
            hi_min = 1000; hi_max = 0; hi_run = 0;
        end else if (spi_clk) hi_run++;
        else if (prev_clk) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
            hi_run = 0;
        end
        if (!spi_cs && prev_cs) begin
            cur_fall = cyc;
            cur_gap  = cs_hi_run;
        end
        if (spi_cs) cs_hi_run++; else cs_hi_run = 0;
        if (spi_cs && !prev_cs) begin
            fr.nbits = cur_nbits; fr.word = cur_word; fr.fall = cur_fall; fr.rise = cyc; fr.gap = cur_gap;
            frames_q.push_back(fr);
            if (cur_nbits == 16 && cur_word[15:8] == 8'h05) rdsr_cnt++;
            cur_nbits = 0;
            cur_word  = 32'h0;
        end
        if (mem_finish) begin
            fin_cnt++;
            fin_cyc = cyc;
        end
        prev_clk = spi_clk;
        prev_cs  = spi_cs;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) @(negedge mclk);
        chk_cnt++; if (spi_cs !== 1'b1) $display("FAIL reset_cs: got %b want 1", spi_cs); else pass_cnt++;
        chk_cnt++; if (spi_clk !== 1'b0) $display("FAIL reset_clk: got %b want 0", spi_clk); else pass_cnt++;
        chk_cnt++; if (spi_mosi !== 1'b0) $display("FAIL reset_mosi: got %b want 0", spi_mosi); else pass_cnt++;
        chk_cnt++; if (mem_finish !== 1'b0) $display("FAIL reset_finish: got %b want 0", mem_finish); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (mem_data_rd !== 8'h00) $display("FAIL reset_data: got %h want 00", mem_data_rd); else pass_cnt++;
        reset = 1'b1;
        repeat (3) @(negedge mclk);
        chk_cnt++; if (spi_cs !== 1'b1 || busy !== 1'b0) $display("FAIL idle_after_reset: cs=%b busy=%b want 1/0", spi_cs, busy); else pass_cnt++;
    endtask

    task automatic test_read();
        int b, base, f0;
        base = frames_q.size(); f0 = fin_cnt; rd_val = 8'h3C;
        mem_addr = 16'h12A5; mem_begin_rd = 1'b1; b = cyc;
        @(negedge mclk); mem_begin_rd = 1'b0;
        chk_cnt++; if (spi_cs !== 1'b0 || busy !== 1'b1) $display("FAIL read_start: cs=%b busy=%b want 0/1", spi_cs, busy); else pass_cnt++;
        chk_cnt++; if (spi_clk !== 1'b0) $display("FAIL read_t0_clk: got %b want 0", spi_clk); else pass_cnt++;
        for (int i = 0; i < 600 && fin_cnt == f0; i++) @(negedge mclk);
        repeat (3) @(negedge mclk);
        chk_cnt++; if (fin_cnt - f0 != 1) $display("FAIL read_finish_count: got %0d want 1", fin_cnt - f0); else pass_cnt++;
        chk_cnt++; if (fin_cyc != b + 261) $display("FAIL read_finish_cycle: got %0d want %0d", fin_cyc, b + 261); else pass_cnt++;
        chk_cnt++; if (mem_data_rd !== 8'h3C) $display("FAIL read_data: got %h want 3c", mem_data_rd); else pass_cnt++;
        chk_cnt++; if (frames_q.size() != base + 1) $display("FAIL read_frames: got %0d want 1", frames_q.size() - base); else pass_cnt++;
        if (frames_q.size() > base) begin
            chk_cnt++; if (frames_q[base].word !== 32'h0312A500 || frames_q[base].nbits != 32)
                $display("FAIL read_mosi: got %h/%0d bits want 0312a500/32", frames_q[base].word, frames_q[base].nbits); else pass_cnt++;
            chk_cnt++; if (frames_q[base].fall != b + 1 || frames_q[base].rise != b + 261)
                $display("FAIL read_cs_window: got %0d..%0d want %0d..%0d", frames_q[base].fall, frames_q[base].rise, b + 1, b + 261); else pass_cnt++;
        end
        chk_cnt++; if (busy !== 1'b0) $display("FAIL read_busy_end: got %b want 0", busy); else pass_cnt++;
    endtask

`ifndef SPI_MEM_MASTER_WIP_POLL_EN
    task automatic test_write();
        int b, base, f0;
        base = frames_q.size(); f0 = fin_cnt;
        mem_addr = 16'hFFFF; mem_data_wr = 8'h81; mem_begin_wr = 1'b1; b = cyc;
        @(negedge mclk); mem_begin_wr = 1'b0;
        for (int i = 0; i < 800 && fin_cnt == f0; i++) @(negedge mclk);
        repeat (20) @(negedge mclk);
        chk_cnt++; if (fin_cnt - f0 != 1) $display("FAIL write_finish_count: got %0d want 1", fin_cnt - f0); else pass_cnt++;
        chk_cnt++; if (frames_q.size() != base + 2) $display("FAIL write_frames: got %0d want 2", frames_q.size() - base); else pass_cnt++;
        if (frames_q.size() >= base + 2) begin
            chk_cnt++; if (frames_q[base].word !== 32'h00000006 || frames_q[base].nbits != 8)
                $display("FAIL write_wren: got %h/%0d bits want 06/8", frames_q[base].word, frames_q[base].nbits); else pass_cnt++;
            chk_cnt++; if (frames_q[base].rise != b + 69) $display("FAIL write_wren_end: got %0d want %0d", frames_q[base].rise, b + 69); else pass_cnt++;
            chk_cnt++; if (frames_q[base + 1].gap != 8) $display("FAIL write_gap: got %0d want 8", frames_q[base + 1].gap); else pass_cnt++;
            chk_cnt++; if (frames_q[base + 1].word !== 32'h02FFFF81 || frames_q[base + 1].nbits != 32)
                $display("FAIL write_frame2: got %h/%0d bits want 02ffff81/32", frames_q[base + 1].word, frames_q[base + 1].nbits); else pass_cnt++;
            chk_cnt++; if (fin_cyc != frames_q[base + 1].rise || fin_cyc != b + 337)
                $display("FAIL write_finish_cycle: got %0d want %0d", fin_cyc, b + 337); else pass_cnt++;
        end
        chk_cnt++; if (mem_data_rd !== 8'h3C) $display("FAIL write_keeps_rdata: got %h want 3c", mem_data_rd); else pass_cnt++;
        chk_cnt++; if (clk_cs_hi != 0) $display("FAIL write_clk_cs_high: got %0d want 0", clk_cs_hi); else pass_cnt++;
    endtask
`else
    task automatic test_poll();
        int b, base, f0;
        base = frames_q.size(); f0 = fin_cnt; wip_frames = rdsr_cnt + 2;
        mem_addr = 16'h0100; mem_data_wr = 8'h55; mem_begin_wr = 1'b1; b = cyc;
        @(negedge mclk); mem_begin_wr = 1'b0;
        for (int i = 0; i < 1500 && fin_cnt == f0; i++) @(negedge mclk);
        repeat (20) @(negedge mclk);
        chk_cnt++; if (fin_cnt - f0 != 1) $display("FAIL poll_finish_count: got %0d want 1", fin_cnt - f0); else pass_cnt++;
        chk_cnt++; if (frames_q.size() != base + 5) $display("FAIL poll_frames: got %0d want 5", frames_q.size() - base); else pass_cnt++;
        if (frames_q.size() >= base + 5) begin
            chk_cnt++; if (frames_q[base + 1].word !== 32'h02010055) $display("FAIL poll_write_frame: got %h want 02010055", frames_q[base + 1].word); else pass_cnt++;
            for (int k = 2; k < 5; k++) begin
                chk_cnt++; if (frames_q[base + k].nbits != 16 || frames_q[base + k].word[15:0] !== 16'h0500 || frames_q[base + k].gap != 8)
                    $display("FAIL poll_rdsr%0d: got %h/%0d bits gap %0d want 0500/16/8", k, frames_q[base + k].word, frames_q[base + k].nbits, frames_q[base + k].gap); else pass_cnt++;
            end
            chk_cnt++; if (fin_cyc != frames_q[base + 4].rise || fin_cyc != b + 757)
                $display("FAIL poll_finish_cycle: got %0d want %0d", fin_cyc, b + 757); else pass_cnt++;
        end
    endtask
`endif

    task automatic test_rd_wins();
        int base, f0;
        base = frames_q.size(); f0 = fin_cnt; rd_val = 8'hA5;
        mem_addr = 16'h0001; mem_data_wr = 8'h77; mem_begin_rd = 1'b1; mem_begin_wr = 1'b1;
        @(negedge mclk); mem_begin_rd = 1'b0; mem_begin_wr = 1'b0;
        repeat (50) @(negedge mclk);
        mem_addr = 16'h2222; mem_begin_wr = 1'b1;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL rdwins_busy: got %b want 1", busy); else pass_cnt++;
        @(negedge mclk); mem_begin_wr = 1'b0;
        for (int i = 0; i < 600 && fin_cnt == f0; i++) @(negedge mclk);
        repeat (60) @(negedge mclk);
        chk_cnt++; if (fin_cnt - f0 != 1) $display("FAIL rdwins_finish_count: got %0d want 1", fin_cnt - f0); else pass_cnt++;
        chk_cnt++; if (frames_q.size() != base + 1) $display("FAIL rdwins_frames: got %0d want 1", frames_q.size() - base); else pass_cnt++;
        if (frames_q.size() > base) begin
            chk_cnt++; if (frames_q[base].word !== 32'h03000100) $display("FAIL rdwins_mosi: got %h want 03000100", frames_q[base].word); else pass_cnt++;
        end
        chk_cnt++; if (mem_data_rd !== 8'hA5) $display("FAIL rdwins_data: got %h want a5", mem_data_rd); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int b, base, f0;
        f0 = fin_cnt; rd_val = 8'h99;
        mem_addr = 16'h0ABC; mem_begin_rd = 1'b1; b = cyc;
        @(negedge mclk); mem_begin_rd = 1'b0;
        for (int i = 0; i < 200 && cyc < b + 101; i++) @(negedge mclk);
        reset = 1'b0;
        @(negedge mclk);
        chk_cnt++; if (spi_cs !== 1'b1 || spi_clk !== 1'b0) $display("FAIL rstmid_pins: cs=%b clk=%b want 1/0", spi_cs, spi_clk); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0 || mem_finish !== 1'b0) $display("FAIL rstmid_status: busy=%b finish=%b want 0/0", busy, mem_finish); else pass_cnt++;
        chk_cnt++; if (mem_data_rd !== 8'h00) $display("FAIL rstmid_data: got %h want 00", mem_data_rd); else pass_cnt++;
        @(negedge mclk); reset = 1'b1;
        repeat (10) @(negedge mclk);
        chk_cnt++; if (fin_cnt != f0) $display("FAIL rstmid_no_finish: got %0d want 0", fin_cnt - f0); else pass_cnt++;
        base = frames_q.size(); rd_val = 8'h5A;
        mem_addr = 16'h4000; mem_begin_rd = 1'b1; b = cyc;
        @(negedge mclk); mem_begin_rd = 1'b0;
        for (int i = 0; i < 600 && fin_cnt == f0; i++) @(negedge mclk);
        repeat (3) @(negedge mclk);
        chk_cnt++; if (fin_cnt - f0 != 1 || fin_cyc != b + 261) $display("FAIL rstmid_reread_finish: got %0d@%0d want 1@%0d", fin_cnt - f0, fin_cyc, b + 261); else pass_cnt++;
        chk_cnt++; if (mem_data_rd !== 8'h5A) $display("FAIL rstmid_reread_data: got %h want 5a", mem_data_rd); else pass_cnt++;
        if (frames_q.size() > base) begin
            chk_cnt++; if (frames_q[base].word !== 32'h03400000) $display("FAIL rstmid_reread_mosi: got %h want 03400000", frames_q[base].word); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int b1, b2, base, f0;
        base = frames_q.size(); f0 = fin_cnt; rd_val = 8'h11;
        mem_addr = 16'h0010; mem_begin_rd = 1'b1; b1 = cyc;
        @(negedge mclk); mem_begin_rd = 1'b0;
        for (int i = 0; i < 600 && mem_finish !== 1'b1; i++) @(negedge mclk);
        chk_cnt++; if (mem_finish !== 1'b1 || cyc != b1 + 261) $display("FAIL b2b_first_finish: got %b@%0d want 1@%0d", mem_finish, cyc, b1 + 261); else pass_cnt++;
        chk_cnt++; if (mem_data_rd !== 8'h11) $display("FAIL b2b_first_data: got %h want 11", mem_data_rd); else pass_cnt++;
        @(negedge mclk);
        rd_val = 8'h22; mem_addr = 16'h0011; mem_begin_rd = 1'b1; b2 = cyc;
        @(negedge mclk); mem_begin_rd = 1'b0;
        chk_cnt++; if (busy !== 1'b1 || spi_cs !== 1'b0) $display("FAIL b2b_accept: busy=%b cs=%b want 1/0", busy, spi_cs); else pass_cnt++;
        for (int i = 0; i < 600 && fin_cnt < f0 + 2; i++) @(negedge mclk);
        repeat (3) @(negedge mclk);
        chk_cnt++; if (fin_cnt - f0 != 2 || fin_cyc != b2 + 261) $display("FAIL b2b_second_finish: got %0d@%0d want 2@%0d", fin_cnt - f0, fin_cyc, b2 + 261); else pass_cnt++;
        chk_cnt++; if (mem_data_rd !== 8'h22) $display("FAIL b2b_second_data: got %h want 22", mem_data_rd); else pass_cnt++;
        if (frames_q.size() >= base + 2) begin
            chk_cnt++; if (frames_q[base + 1].gap < 1 || frames_q[base + 1].word !== 32'h03001100)
                $display("FAIL b2b_frame2: gap %0d word %h want >=1 / 03001100", frames_q[base + 1].gap, frames_q[base + 1].word); else pass_cnt++;
        end
        chk_cnt++; if (hi_min != 4 || hi_max != 4) $display("FAIL b2b_clk_high_width: got %0d..%0d want 4..4", hi_min, hi_max); else pass_cnt++;
        chk_cnt++; if (clk_cs_hi != 0) $display("FAIL clk_while_cs_high: got %0d want 0", clk_cs_hi); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b0; mem_begin_rd = 1'b0; mem_begin_wr = 1'b0;
        mem_addr = 16'h0000; mem_data_wr = 8'h00;
        @(negedge mclk);
        test_reset();
        test_read();
`ifdef SPI_MEM_MASTER_WIP_POLL_EN
        test_poll();
`else
        test_write();
`endif
        test_rd_wins();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
